wiegand_rx_multi: RTL and testbench

Parametrised Wiegand access-control receiver, the next generation of the board-controller Wiegand input logic.
- Samples the active-low D0/D1 line pair, filters glitches, and assembles variable-length frames of up to MAX_BITS bits.
- Ends a frame on an inter-frame idle timeout, then checks standard leading-even/trailing-odd parity.
- Queues completed frames in a small FIFO and presents them to the host read logic on a valid/ready handshake with a level interrupt.

---
 rtl/wiegand_pkg.sv | 36 +++
 rtl/wiegand_rx_multi_if.sv | 18 +
 rtl/wiegand_frame_fifo.sv | 69 ++++++
 rtl/wiegand_rx_multi.sv | 191 +++++++++++++++++++
 tb/tb_wiegand_rx_multi.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/wiegand_pkg.sv
// Shared types for the Wiegand receiver: FSM states, the queued frame record
// and the leading-even / trailing-odd parity check.
package wiegand_pkg;

  // Frame records are sized for the largest supported frame; instances with
  // MAX_BITS <= WG_DATA_W and LEN_W <= WG_LEN_W zero-extend into them.
  localparam int WG_DATA_W = 64;
  localparam int WG_LEN_W  = 7;

  typedef enum logic [1:0] {IDLE, RECV, FLUSH} state_t;

  typedef struct packed {
    logic [WG_DATA_W-1:0] data;
    logic [WG_LEN_W-1:0]  len;
    logic                 par_ok;
  } frame_t;

  // data is right-justified, so the first received half sits in [len-1:len/2].
  function automatic logic parity_ok(input logic [WG_DATA_W-1:0] data,
                                     input logic [WG_LEN_W-1:0]  len);
    logic [WG_LEN_W-1:0] half;
    logic lo_par;
    logic hi_par;
    half   = len >> 1;
    lo_par = 1'b0;
    hi_par = 1'b0;
    for (int i = 0; i < WG_DATA_W; i++) begin
      if (i < int'(half))
        lo_par = lo_par ^ data[i];
      else if (i < int'(len))
        hi_par = hi_par ^ data[i];
    end
    return !len[0] && (len != '0) && !hi_par && lo_par;
  endfunction

endpackage

// File: rtl/wiegand_rx_multi_if.sv
// Host-side frame handshake of the Wiegand receiver: head frame, valid/ready
// and the level interrupt.
interface wiegand_rx_multi_if #(
  parameter int MAX_BITS = 64,
  parameter int LEN_W    = 7
);
  logic [MAX_BITS-1:0] frm_data;
  logic [LEN_W-1:0]    frm_len;
  logic                frm_par_ok;
  logic                frm_valid;
  logic                frm_ready;
  logic                irq;

  modport master (output frm_data, frm_len, frm_par_ok, frm_valid, irq,
                  input  frm_ready);
  modport slave  (input  frm_data, frm_len, frm_par_ok, frm_valid, irq,
                  output frm_ready);
endinterface

// File: rtl/wiegand_frame_fifo.sv
// Frame-record FIFO; the head record is registered and follows the queue one
// edge after a push into an empty FIFO or after a pop.
module wiegand_frame_fifo
  import wiegand_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic   clk,
  input  logic   nReset,
  input  logic   push,
  input  frame_t push_data,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output frame_t head
);
  localparam int AW = $clog2(DEPTH);

  frame_t        mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] rd_ptr_inc;
  logic [AW:0]   count_reg;
  frame_t        head_reg;
  logic          do_pop;
  logic          do_push;

  assign full       = (count_reg == (AW+1)'(DEPTH));
  assign empty      = (count_reg == '0);
  assign do_pop     = pop && !empty;
  // A full FIFO still accepts a push when the same cycle pops.
  assign do_push    = push && (!full || do_pop);
  assign rd_ptr_inc = rd_ptr_reg + 1'b1;
  assign head       = head_reg;

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      head_reg   <= '0;
    end else begin
      if (do_push)
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)
        rd_ptr_reg <= rd_ptr_inc;
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: ;
      endcase
      // Head holds its last value once the FIFO drains.
      if (do_pop) begin
        if (count_reg > (AW+1)'(1))
          head_reg <= mem[rd_ptr_inc];
        else if (do_push)
          head_reg <= push_data;
      end else if (do_push && empty) begin
        head_reg <= push_data;
      end
    end
  end

endmodule

// File: rtl/wiegand_rx_multi.sv
// Wiegand receiver: synchronise and de-glitch D0/D1, assemble variable-length
// frames ended by an idle gap, check parity and queue them for the host.
module wiegand_rx_multi
  import wiegand_pkg::*;
#(
  parameter int MAX_BITS   = 64,
  parameter int MIN_BITS   = 4,
  parameter int LEN_W      = 7,
  parameter int FILT       = 4,
  parameter int GAP_CYCLES = 10000,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                nReset,
  input  logic [1:0]          wil,
  wiegand_rx_multi_if.master  frm,
  output logic                ovf,
  output logic                err,
  input  logic                clr
);
  localparam int FW = $clog2(FILT + 1);
  localparam int IW = $clog2(GAP_CYCLES + 1);

  logic [1:0] filt_lvl;
  logic [1:0] fall;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_line
      logic [1:0]    sync_reg;
      logic [FW-1:0] fcnt_reg;
      logic          filt_reg;
      logic          armed_reg;
      logic          flip;

      assign flip         = (sync_reg[1] != filt_reg) && (fcnt_reg == FW'(FILT - 1));
      // A line low at reset release must be seen high before it can clock a bit.
      assign fall[gi]     = flip && filt_reg && armed_reg;
      assign filt_lvl[gi] = filt_reg;

      always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
          sync_reg  <= 2'b00;
          fcnt_reg  <= '0;
          filt_reg  <= 1'b1;
          armed_reg <= 1'b0;
        end else begin
          sync_reg  <= {sync_reg[0], wil[gi]};
          armed_reg <= armed_reg || (sync_reg[1] && filt_reg);
          if ((sync_reg[1] == filt_reg) || flip)
            fcnt_reg <= '0;
          else
            fcnt_reg <= fcnt_reg + 1'b1;
          if (flip)
            filt_reg <= ~filt_reg;
        end
      end
    end
  endgenerate

  logic bit_ev;
  logic bit_val;
  logic both_low;

  assign bit_ev   = |fall;
  assign bit_val  = fall[1];
  assign both_low = (filt_lvl == 2'b00);

  state_t              state_reg;
  state_t              state_next;
  logic [MAX_BITS-1:0] shreg_reg;
  logic [LEN_W-1:0]    cnt_reg;
  logic [IW-1:0]       idle_reg;
  logic                bad_reg;
  logic                ovf_reg;
  logic                err_reg;
  logic                start;
  logic                shift;
  logic                frame_ok;
  logic                push;
  logic                pop;
  logic                err_set;
  logic                ovf_set;
  logic                fifo_full;
  logic                fifo_empty;
  frame_t              push_data;
  frame_t              head;

  assign frame_ok = !bad_reg && (cnt_reg >= LEN_W'(MIN_BITS));
  assign pop      = frm.frm_ready && !fifo_empty;

  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    shift      = 1'b0;
    push       = 1'b0;
    err_set    = 1'b0;
    ovf_set    = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bit_ev) begin
          state_next = RECV;
          start      = 1'b1;
        end
      end
      RECV: begin
        if (bit_ev)
          shift = 1'b1;
        else if (idle_reg == IW'(GAP_CYCLES - 1))
          state_next = FLUSH;
      end
      FLUSH: begin
        push    = frame_ok;
        err_set = !frame_ok;
        ovf_set = frame_ok && fifo_full && !pop;
        if (bit_ev) begin
          state_next = RECV;
          start      = 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      state_reg <= IDLE;
      shreg_reg <= '0;
      cnt_reg   <= '0;
      idle_reg  <= '0;
      bad_reg   <= 1'b0;
      ovf_reg   <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (start) begin
        shreg_reg <= {{(MAX_BITS-1){1'b0}}, bit_val};
        cnt_reg   <= LEN_W'(1);
        idle_reg  <= '0;
        bad_reg   <= both_low;
      end else if (state_reg == RECV) begin
        if (shift) begin
          shreg_reg <= {shreg_reg[MAX_BITS-2:0], bit_val};
          idle_reg  <= '0;
          if (cnt_reg != LEN_W'(MAX_BITS + 1))
            cnt_reg <= cnt_reg + 1'b1;
        end else begin
          idle_reg <= idle_reg + 1'b1;
        end
        // Reaching MAX_BITS+1 bits poisons the frame as too long.
        if (both_low || (shift && (cnt_reg >= LEN_W'(MAX_BITS))))
          bad_reg <= 1'b1;
      end
      if (ovf_set)
        ovf_reg <= 1'b1;
      else if (clr)
        ovf_reg <= 1'b0;
      if (err_set)
        err_reg <= 1'b1;
      else if (clr)
        err_reg <= 1'b0;
    end
  end

  assign push_data.data   = WG_DATA_W'(shreg_reg);
  assign push_data.len    = WG_LEN_W'(cnt_reg);
  assign push_data.par_ok = parity_ok(WG_DATA_W'(shreg_reg), WG_LEN_W'(cnt_reg));

  wiegand_frame_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .nReset    (nReset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .head      (head)
  );

  assign frm.frm_data   = head.data[MAX_BITS-1:0];
  assign frm.frm_len    = head.len[LEN_W-1:0];
  assign frm.frm_par_ok = head.par_ok;
  assign frm.frm_valid  = !fifo_empty;
  assign frm.irq        = !fifo_empty;
  assign ovf            = ovf_reg;
  assign err            = err_reg;

endmodule

// File: tb/tb_wiegand_rx_multi.sv
// Directed bench for wiegand_rx_multi: glitch rejection, frame decode, FIFO
// overflow, error frames and reset mid-frame.
module tb_wiegand_rx_multi;
  import wiegand_pkg::*;

  localparam int GAP = 300;

  logic       clk = 1'b0;
  logic       nReset;
  logic [1:0] wil;
  logic       ovf;
  logic       err;
  logic       clr;

  int checks   = 0;
  int failures = 0;

  logic [7:0] ov_val [5] = '{8'h31, 8'h22, 8'h0E, 8'h44, 8'h55};
  logic       ov_par [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

  wiegand_rx_multi_if #(.MAX_BITS(64), .LEN_W(7)) fif ();

  wiegand_rx_multi #(
    .MAX_BITS   (64),
    .MIN_BITS   (4),
    .LEN_W      (7),
    .FILT       (4),
    .GAP_CYCLES (GAP),
    .FIFO_DEPTH (4)
  ) dut (
    .clk    (clk),
    .nReset (nReset),
    .wil    (wil),
    .frm    (fif),
    .ovf    (ovf),
    .err    (err),
    .clr    (clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, input int lo, input int hi);
    wil[int'(b)] = 1'b0;
    tick(lo);
    wil[int'(b)] = 1'b1;
    tick(hi);
  endtask

  task automatic send_frame(input logic [79:0] v, input int n, input int lo, input int hi);
    for (int i = n - 1; i >= 0; i--)
      send_bit(v[i], lo, hi);
    tick(GAP + 20);
  endtask

  task automatic pop_one();
    fif.frm_ready = 1'b1;
    tick(1);
    fif.frm_ready = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
  endtask

  task automatic check_head(input string tag, input logic [63:0] d, input int n, input logic p);
    check({tag, "_valid"}, 64'(fif.frm_valid), 64'd1);
    check({tag, "_irq"},   64'(fif.irq),       64'd1);
    check({tag, "_data"},  fif.frm_data,       d);
    check({tag, "_len"},   64'(fif.frm_len),   64'(n));
    check({tag, "_par"},   64'(fif.frm_par_ok), 64'(p));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, 64'(fif.frm_valid),  64'd0);
    check({tag, "_irq"},   64'(fif.irq),        64'd0);
    check({tag, "_data"},  fif.frm_data,        64'd0);
    check({tag, "_len"},   64'(fif.frm_len),    64'd0);
    check({tag, "_par"},   64'(fif.frm_par_ok), 64'd0);
    check({tag, "_ovf"},   64'(ovf),            64'd0);
    check({tag, "_err"},   64'(err),            64'd0);
  endtask

  initial begin
    nReset        = 1'b0;
    wil           = 2'b11;
    clr           = 1'b0;
    fif.frm_ready = 1'b0;
    tick(5);
    check_all_zero("reset");
    nReset = 1'b1;
    tick(10);

    // 2-cycle glitch on D0 must not register as a bit
    wil[0] = 1'b0;
    tick(2);
    wil[0] = 1'b1;
    tick(GAP + 20);
    check("glitch_valid", 64'(fif.frm_valid), 64'd0);
    check("glitch_err",   64'(err),           64'd0);
    $display("glitch pulse: valid=%0d err=%0d", fif.frm_valid, err);

    // 26-bit frame, slow pulses
    send_frame(80'h127C94D, 26, 100, 100);
    check_head("frameA", 64'h127C94D, 26, 1'b0);
    $display("frameA: data=0x%0h len=%0d par=%0d", fif.frm_data, fif.frm_len, fif.frm_par_ok);
    pop_one();
    check("popA_valid", 64'(fif.frm_valid), 64'd0);
    check("popA_irq",   64'(fif.irq),       64'd0);
    check("popA_hold",  fif.frm_data,       64'h127C94D);

    // 25 zeros then a one: good parity
    send_frame(80'h1, 26, 20, 20);
    check_head("frameB", 64'h1, 26, 1'b1);
    $display("frameB: data=0x%0h len=%0d par=%0d", fif.frm_data, fif.frm_len, fif.frm_par_ok);
    pop_one();

    // Five frames into a four-deep FIFO with no host pops
    for (int k = 0; k < 5; k++)
      send_frame(80'(ov_val[k]), 8, 20, 20);
    check("ovf_set",   64'(ovf), 64'd1);
    check("ovf_noerr", 64'(err), 64'd0);
    for (int k = 0; k < 4; k++) begin
      check_head($sformatf("ovf_pop%0d", k), 64'(ov_val[k]), 8, ov_par[k]);
      $display("overflow pop %0d: data=0x%0h par=%0d", k, fif.frm_data, fif.frm_par_ok);
      pop_one();
    end
    check("ovf_drained", 64'(fif.frm_valid), 64'd0);
    pulse_clr();
    check("ovf_clr", 64'(ovf), 64'd0);

    // Too short
    send_frame(80'b101, 3, 20, 20);
    check("short_err",   64'(err),           64'd1);
    check("short_valid", 64'(fif.frm_valid), 64'd0);
    $display("3-bit frame: err=%0d valid=%0d", err, fif.frm_valid);
    pulse_clr();
    check("short_clr", 64'(err), 64'd0);

    // Too long
    send_frame(80'h0, 65, 10, 10);
    check("long_err",   64'(err),           64'd1);
    check("long_valid", 64'(fif.frm_valid), 64'd0);
    $display("65-bit frame: err=%0d valid=%0d", err, fif.frm_valid);
    pulse_clr();

    // Both lines low mid-frame, then a clean frame
    for (int i = 0; i < 5; i++)
      send_bit(1'(i & 1), 10, 10);
    wil = 2'b00;
    tick(10);
    wil = 2'b11;
    tick(GAP + 30);
    check("both_err",   64'(err),           64'd1);
    check("both_valid", 64'(fif.frm_valid), 64'd0);
    $display("both-low frame: err=%0d valid=%0d", err, fif.frm_valid);
    pulse_clr();
    send_frame(80'h127C94D, 26, 10, 10);
    check_head("after_both", 64'h127C94D, 26, 1'b0);
    check("after_both_err", 64'(err), 64'd0);
    $display("frame after both-low: data=0x%0h len=%0d", fif.frm_data, fif.frm_len);

    // Leave a frame queued and err set, then reset in the middle of a frame
    send_frame(80'b111, 3, 10, 10);
    check("pre_rst_err", 64'(err), 64'd1);
    for (int i = 0; i < 10; i++)
      send_bit(1'(i & 1), 20, 20);
    nReset = 1'b0;
    #1;
    check_all_zero("midrst");
    $display("reset mid-frame: valid=%0d err=%0d", fif.frm_valid, err);
    tick(3);
    nReset = 1'b1;
    tick(10);
    send_frame(80'h127C94D, 26, 20, 20);
    check_head("post_rst", 64'h127C94D, 26, 1'b0);
    $display("frame after reset: data=0x%0h len=%0d", fif.frm_data, fif.frm_len);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
